ov7670_frame_capture: RTL
=========================

OV7670_FRAME_CAPTURE -- requirements
Module: ov7670_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, 640, active pixels per sensor line.
REQ-002 SHALL have parameter HEIGHT, 480, active lines per sensor frame.
REQ-003 SHALL have parameter DECIM, 1, decimation factor in both axes; legal values are 1, 2 and 4.
REQ-004 SHALL have parameter ADDR_W, 19, output address width; must be at least clog2((WIDTH/DECIM)*(HEIGHT/DECIM)).
REQ-005 SHALL have port pclk, input, 1, sole clock (sensor pixel clock, rising edge).
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port vsync, input, 1, sensor vertical sync; high = blanking.
REQ-008 SHALL have port href, input, 1, sensor line valid.
REQ-009 SHALL have port din, input, 8, sensor data byte.
REQ-010 SHALL have port arm, input, 1, start request for a capture.
REQ-011 SHALL have port cont, input, 1, 1 = continuous frames, 0 = single frame.
REQ-012 SHALL have port fmt, input, 1, 0 = YUV422 Y-first gray, 1 = RGB565 high-byte-first.
REQ-013 SHALL have port addr, output, ADDR_W, write address.
REQ-014 SHALL have port dout, output, 12, RGB444 pixel {r,g,b}.
REQ-015 SHALL have port we, output, 1, write strobe.
REQ-016 SHALL have port busy, output, 1, high while in WAIT_VS or ACTIVE.
REQ-017 SHALL have port capture_end, output, 1, frame complete, level.
REQ-018 SHALL have port err, output, 1, sticky framing error.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_VS, ACTIVE and DONE.
REQ-020 SHALL move IDLE->WAIT_VS on arm=1.
REQ-021 SHALL move WAIT_VS->ACTIVE on a registered vsync falling edge (vsync 1 then 0 on consecutive pclk edges), and SHALL latch fmt and cont on that transition.
REQ-022 SHALL leave ACTIVE on a vsync rising edge: to WAIT_VS if latched cont=1, else to DONE.
REQ-023 SHALL hold capture_end=1 throughout DONE and move DONE->WAIT_VS on arm=1.
REQ-024 SHALL pulse capture_end for 1 cycle on each frame end in continuous mode.
REQ-025 SHALL ignore arm while in WAIT_VS or ACTIVE.
REQ-026 SHALL toggle the byte phase on every pclk with href=1 in ACTIVE; the phase resets to 0 whenever href=0.
REQ-027 SHALL treat phase-0 byte as b0 and phase-1 byte as b1; b1 completes one pixel.
REQ-028 SHALL produce dout={b0[7:4],b0[7:4],b0[7:4]} when latched fmt=0.
REQ-029 SHALL produce dout={b0[7:4],b0[2:0],b1[7],b1[4:1]} (r4,g4,b4 of RGB565) when latched fmt=1.
REQ-030 SHALL keep column counter col (0..WIDTH-1, pixels) and row counter row; col clears on each href falling edge; row increments on each href falling edge and clears on entry to ACTIVE.
REQ-031 SHALL keep a pixel only if col%DECIM==0, row%DECIM==0, col<WIDTH and row<HEIGHT.
REQ-032 SHALL compute addr = line_base + col/DECIM; line_base clears on entry to ACTIVE and adds WIDTH/DECIM after each kept row's href falling edge; no multiplier permitted.
REQ-033 SHALL register addr, dout and we together; we is high exactly 1 cycle, the pclk edge after the b1 edge of a kept pixel.
REQ-034 SHALL never assert we outside ACTIVE.
REQ-035 SHALL suppress pixels with col>=WIDTH or row>=HEIGHT and set err.
REQ-036 SHALL discard an odd partial pixel when href falls at phase 1 and set err.
REQ-037 SHALL set err when vsync rises while href=1, ending the frame per REQ-022.
REQ-038 SHALL clear err only on reset or on entry to ACTIVE.
REQ-039 SHALL permit arm and a vsync falling edge on the same cycle in IDLE; capture then begins at the next falling edge, not the current one.

Reset
REQ-040 SHALL, while rst=1, force state IDLE and addr=0, dout=0, we=0, busy=0, capture_end=0, err=0, with all counters and the byte phase at 0.
REQ-041 SHALL, when rst asserts mid-frame, abandon the frame without a further we; after release, capture requires a new arm.

Verification
REQ-042 SHALL verify: WIDTH=8, HEIGHT=4, DECIM=1, fmt=1, cont=0, arm, then one frame with b0=0xF8,b1=0x1F per pixel -> 32 writes, addr 0..31, dout=0xF0F, capture_end stays 1 in DONE.
REQ-043 SHALL verify: same frame with DECIM=2 -> 8 writes, addr 0..7, rows 0 and 2 only, columns 0, 2, 4 and 6 only.
REQ-044 SHALL verify: fmt=0, Y bytes 0xA5 -> dout=0xAAA; fmt toggled mid-frame -> no effect until the next frame.
REQ-045 SHALL verify: 9-pixel line at WIDTH=8 -> 8 writes on that line, err=1; an odd byte count -> last byte dropped, err=1.
REQ-046 SHALL verify: arm asserted mid-frame -> no we until after the next vsync falling edge; cont=1 -> capture_end 1-cycle pulse per frame with addr restarting at 0.
REQ-047 SHALL verify: rst pulse during ACTIVE -> all outputs 0 within the same cycle, state IDLE, no we until a fresh arm and frame.

Source files
------------

// File: rtl/ov7670_frame_capture.sv
// ov7670_frame_capture
//   Captures frames from an OV7670-style camera bus into a write port for a
//   frame buffer, with optional decimation. Bytes arrive as pairs: b0 then b1.
//   Each pair is converted to an RGB444 pixel. The pixel can be YUV422 gray
//   (Y byte first) or RGB565 (high byte first).
//
// Ports
//   pclk        sensor pixel clock, sole clock (rising edge)
//   rst         asynchronous active-high reset
//   vsync       sensor vertical sync, high = blanking
//   href        sensor line valid
//   din[7:0]    sensor data byte
//   arm         capture start request
//   cont        1 = continuous frames, 0 = single frame (latched at frame start)
//   fmt         0 = YUV422 gray, 1 = RGB565 (latched at frame start)
//   addr        frame buffer write address
//   dout[11:0]  RGB444 pixel {r,g,b}
//   we          one-cycle write strobe, registered together with addr/dout
//   busy        high while waiting for a frame or capturing one
//   capture_end level in DONE; one-cycle pulse per frame in continuous mode
//   err         sticky framing error, cleared on reset or at frame start
//
// state   | meaning
// IDLE    | after reset, waiting for arm
// WAIT_VS | armed, waiting for a vsync falling edge
// ACTIVE  | capturing the current frame
// DONE    | single frame complete, capture_end held high until re-armed
module ov7670_frame_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  input  logic              arm,
  input  logic              cont,
  input  logic              fmt,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       dout,
  output logic              we,
  output logic              busy,
  output logic              capture_end,
  output logic              err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  // DECIM is restricted to 1, 2 or 4, so divide and modulo are shift and mask.
  localparam int SH = (DECIM == 4) ? 2 : ((DECIM == 2) ? 1 : 0);
  localparam logic [CW-1:0]     WIDTH_C   = CW'(WIDTH);
  localparam logic [RW-1:0]     HEIGHT_C  = RW'(HEIGHT);
  localparam logic [CW-1:0]     CMASK     = CW'(DECIM - 1);
  localparam logic [RW-1:0]     RMASK     = RW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH / DECIM);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic              vsync_q, href_q;
  logic              vs_fall, vs_rise, href_fall;
  logic              start, frame_end;
  logic              fmt_l, cont_l;
  logic              phase;
  logic [3:0]        b0_hi;
  logic [2:0]        b0_lo;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] line_base;
  logic              ce_pulse;
  logic              in_frame, col_kept, row_kept;

  assign vs_fall   = vsync_q & ~vsync;
  assign vs_rise   = ~vsync_q & vsync;
  assign href_fall = href_q & ~href;

  assign in_frame = (col < WIDTH_C) && (row < HEIGHT_C);
  assign col_kept = ((col & CMASK) == '0);
  assign row_kept = (row < HEIGHT_C) && ((row & RMASK) == '0);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (arm) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_fall) begin
        state_nxt = ACTIVE;
        start     = 1'b1;
      end
      ACTIVE:  if (vs_rise) begin
        state_nxt = cont_l ? WAIT_VS : DONE;
        frame_end = 1'b1;
      end
      DONE:    if (arm) state_nxt = WAIT_VS;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      fmt_l     <= 1'b0;
      cont_l    <= 1'b0;
      phase     <= 1'b0;
      b0_hi     <= '0;
      b0_lo     <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      addr      <= '0;
      dout      <= '0;
      we        <= 1'b0;
      err       <= 1'b0;
      ce_pulse  <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      href_q   <= href;
      we       <= 1'b0;
      ce_pulse <= frame_end & cont_l;
      if (start) begin
        fmt_l     <= fmt;
        cont_l    <= cont;
        phase     <= 1'b0;
        col       <= '0;
        row       <= '0;
        line_base <= '0;
        err       <= 1'b0;
      end else if (state == ACTIVE) begin
        if (vs_rise) begin
          // Frame ended in the middle of a line.
          if (href) err <= 1'b1;
          phase <= 1'b0;
        end else if (href) begin
          if (!phase) begin
            b0_hi <= din[7:4];
            b0_lo <= din[2:0];
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (in_frame) begin
              if (col_kept && row_kept) begin
                we   <= 1'b1;
                addr <= line_base + ADDR_W'(col >> SH);
                dout <= fmt_l ? {b0_hi, b0_lo, din[7], din[4:1]}
                              : {b0_hi, b0_hi, b0_hi};
              end
            end else begin
              err <= 1'b1;
            end
            // col saturates at WIDTH so every later pixel on the line stays suppressed.
            if (col < WIDTH_C) col <= col + 1'b1;
          end
        end else begin
          phase <= 1'b0;
          if (href_fall) begin
            // A pending b0 at line end is an odd partial pixel; drop it.
            if (phase) err <= 1'b1;
            col <= '0;
            if (row < HEIGHT_C) row <= row + 1'b1;
            if (row_kept) line_base <= line_base + LINE_STEP;
          end
        end
      end
    end
  end

  assign busy        = (state == WAIT_VS) || (state == ACTIVE);
  assign capture_end = (state == DONE) || ce_pulse;

endmodule
